// File: rtl/arb_mux_pkg.sv
// Shared mode encodings and elaboration helpers for the registered arbitrating mux.
package arb_mux_pkg;

   localparam logic [1:0] MODE_KEY   = 2'd0;
   localparam logic [1:0] MODE_FIXED = 2'd1;
   localparam logic [1:0] MODE_RR    = 2'd2;

   // Ceiling log2, used only on elaboration-time constants.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((1 << r) < value) begin
            r = r + 1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/arb_mux_reg_rr_pick.sv
// Rotating-priority picker: first asserted request at or after ptr, wrapping.
// With ptr tied to zero it degenerates into a fixed lowest-index priority encoder.
module rr_pick #(
   parameter int N  = 4,
   parameter int PW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [PW-1:0] idx,
   output logic          any
);

   logic [PW:0] cand;

   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      cand  = '0;
      for (int k = 0; k < N; k++) begin
         // ptr < N and k < N, so one conditional subtract is a full modulo-N wrap
         cand = {1'b0, ptr} + (PW + 1)'(k);
         if (cand >= (PW + 1)'(N)) begin
            cand = cand - (PW + 1)'(N);
         end
         if (!any && req[cand[PW-1:0]]) begin
            any              = 1'b1;
            idx              = cand[PW-1:0];
            grant[cand[PW-1:0]] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/arb_mux_reg.sv
// Registered N-channel mux with valid/ready on every port; selection by key,
// fixed priority or round-robin, chosen per cycle by mode.
module arb_mux_reg
   import arb_mux_pkg::*;
#(
   parameter int NR_CH    = 4,
   parameter int DATA_LEN = 2,
   localparam int SEL_W   = (clog2(NR_CH) > 1) ? clog2(NR_CH) : 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [1:0]                mode,
   input  logic [SEL_W-1:0]          sel,
   input  logic [NR_CH-1:0]          in_valid,
   output logic [NR_CH-1:0]          in_ready,
   input  logic [NR_CH*DATA_LEN-1:0] in_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [DATA_LEN-1:0]       out_data,
   output logic [SEL_W-1:0]          out_ch,
   output logic                      sel_err
);

   logic [DATA_LEN-1:0] ch_data [NR_CH];

   logic                out_valid_reg;
   logic [DATA_LEN-1:0] out_data_reg;
   logic [SEL_W-1:0]    out_ch_reg;
   logic [SEL_W-1:0]    ptr_reg;
   logic                sel_err_reg;

   logic                can_accept;
   logic [SEL_W-1:0]    pick_ptr;
   logic [SEL_W-1:0]    pick_idx;
   logic [NR_CH-1:0]    pick_oh;
   logic                pick_any;

   logic                sel_ok;
   logic                key_hit;
   logic [NR_CH-1:0]    key_oh;

   logic                grant_vld;
   logic [SEL_W-1:0]    grant_idx;
   logic [NR_CH-1:0]    grant_oh;
   logic [SEL_W-1:0]    ptr_next;

   generate
      for (genvar gi = 0; gi < NR_CH; gi++) begin : g_unpack
         assign ch_data[gi] = in_data[gi*DATA_LEN +: DATA_LEN];
      end
   endgenerate

   assign can_accept = !out_valid_reg || out_ready;

   // Fixed priority (modes 1 and 3) shares the picker with the pointer forced to 0.
   assign pick_ptr = (mode == MODE_RR) ? ptr_reg : '0;

   rr_pick #(
      .N  (NR_CH),
      .PW (SEL_W)
   ) u_pick (
      .req   (in_valid),
      .ptr   (pick_ptr),
      .grant (pick_oh),
      .idx   (pick_idx),
      .any   (pick_any)
   );

   // Decoding by comparison keeps out-of-range keys from indexing past in_valid.
   always_comb begin
      sel_ok  = 1'b0;
      key_hit = 1'b0;
      key_oh  = '0;
      for (int i = 0; i < NR_CH; i++) begin
         if (sel == SEL_W'(i)) begin
            sel_ok    = 1'b1;
            key_hit   = in_valid[i];
            key_oh[i] = 1'b1;
         end
      end
   end

   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      grant_oh  = '0;
      if (!rst && can_accept) begin
         if (mode == MODE_KEY) begin
            grant_vld = key_hit;
            grant_idx = sel;
            grant_oh  = key_hit ? key_oh : '0;
         end else begin
            grant_vld = pick_any;
            grant_idx = pick_idx;
            grant_oh  = pick_oh;
         end
      end
   end

   assign ptr_next = (grant_idx == SEL_W'(NR_CH - 1)) ? '0 : grant_idx + SEL_W'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_reg <= 1'b0;
         out_data_reg  <= '0;
         out_ch_reg    <= '0;
         ptr_reg       <= '0;
         sel_err_reg   <= 1'b0;
      end else begin
         sel_err_reg <= (mode == MODE_KEY) && can_accept && !sel_ok;
         if (grant_vld) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= ch_data[grant_idx];
            out_ch_reg    <= grant_idx;
            if (mode == MODE_RR) begin
               ptr_reg <= ptr_next;
            end
         end else if (out_ready) begin
            out_valid_reg <= 1'b0;
         end
      end
   end

   assign in_ready  = grant_oh;
   assign out_valid = out_valid_reg;
   assign out_data  = out_data_reg;
   assign out_ch    = out_ch_reg;
   assign sel_err   = sel_err_reg;

endmodule

// File: tb/tb_arb_mux_reg.sv
// Scoreboarded bench for arb_mux_reg: a 4-channel instance tracked by a reference
// model, plus a 3-channel instance for the out-of-range key error pulse.
module tb_arb_mux_reg;

   localparam int N = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] mode;
   logic [1:0] sel;
   logic [3:0] in_valid;
   logic [7:0] in_data;
   logic       out_ready;

   logic [3:0] in_ready;
   logic       out_valid;
   logic [1:0] out_data;
   logic [1:0] out_ch;
   logic       sel_err;

   logic [2:0] in_ready3;
   logic       out_valid3;
   logic [1:0] out_data3;
   logic [1:0] out_ch3;
   logic       sel_err3;

   int checks   = 0;
   int failures = 0;

   logic [3:0] sb [$];
   logic       m_valid;
   logic [1:0] m_data;
   logic [1:0] m_ch;
   logic [1:0] m_ptr;

   always #5 clk = ~clk;

   arb_mux_reg #(.NR_CH(4), .DATA_LEN(2)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .mode      (mode),
      .sel       (sel),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_ch    (out_ch),
      .sel_err   (sel_err)
   );

   arb_mux_reg #(.NR_CH(3), .DATA_LEN(2)) u_dut3 (
      .clk       (clk),
      .rst       (rst),
      .mode      (mode),
      .sel       (sel),
      .in_valid  (in_valid[2:0]),
      .in_ready  (in_ready3),
      .in_data   (in_data[5:0]),
      .out_valid (out_valid3),
      .out_ready (out_ready),
      .out_data  (out_data3),
      .out_ch    (out_ch3),
      .sel_err   (sel_err3)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: model grant at the negedge, scoreboard push, then check outputs after the edge.
   task automatic step();
      logic       can;
      logic       hit;
      logic [1:0] g;
      logic [3:0] exp_rdy;
      logic       exp_err;
      logic [3:0] e;
      int         c;
      @(negedge clk);
      can = !m_valid || out_ready;
      hit = 1'b0;
      g   = 2'd0;
      if (!rst && can) begin
         if (mode == 2'd0) begin
            if (int'(sel) < N && in_valid[sel]) begin
               hit = 1'b1;
               g   = sel;
            end
         end else begin
            for (int k = 0; k < N; k++) begin
               c = (mode == 2'd2) ? (int'(m_ptr) + k) % N : k;
               if (!hit && in_valid[c]) begin
                  hit = 1'b1;
                  g   = 2'(c);
               end
            end
         end
      end
      exp_rdy = hit ? (4'b0001 << g) : 4'b0000;
      exp_err = !rst && (mode == 2'd0) && can && (int'(sel) >= N);
      check("in_ready", 32'(in_ready), 32'(exp_rdy));
      if (hit) sb.push_back({g, in_data[g*2 +: 2]});
      @(posedge clk);
      #1;
      if (rst) begin
         m_valid = 1'b0;
         m_data  = 2'd0;
         m_ch    = 2'd0;
         m_ptr   = 2'd0;
      end else if (hit) begin
         if (sb.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
         end else begin
            e = sb.pop_front();
            m_ch    = e[3:2];
            m_data  = e[1:0];
            m_valid = 1'b1;
            $display("xfer mode=%0d ch=%0d data=%0h", mode, m_ch, m_data);
         end
         if (mode == 2'd2) m_ptr = (g == 2'd3) ? 2'd0 : g + 2'd1;
      end else if (m_valid && out_ready) begin
         m_valid = 1'b0;
      end
      check("out_valid", 32'(out_valid), 32'(m_valid));
      check("out_data", 32'(out_data), 32'(m_data));
      check("out_ch", 32'(out_ch), 32'(m_ch));
      check("sel_err", 32'(sel_err), 32'(exp_err));
   endtask

   task automatic drive(input logic [1:0] md, input logic [1:0] sl, input logic [3:0] vl,
                        input logic [7:0] dt, input logic ordy, input int cycles);
      mode      = md;
      sel       = sl;
      in_valid  = vl;
      in_data   = dt;
      out_ready = ordy;
      for (int i = 0; i < cycles; i++) step();
   endtask

   initial begin
      m_valid   = 1'b0;
      m_data    = 2'd0;
      m_ch      = 2'd0;
      m_ptr     = 2'd0;
      rst       = 1'b1;
      mode      = 2'd1;
      sel       = 2'd0;
      in_valid  = 4'hF;
      in_data   = 8'hE4;
      out_ready = 1'b1;

      // reset with every channel requesting
      step();
      step();
      rst = 1'b0;
      drive(2'd1, 2'd0, 4'b1111, 8'hE4, 1'b1, 1);

      // fixed priority: ch1 beats ch3 every cycle
      drive(2'd1, 2'd0, 4'b1010, 8'b11_00_01_00, 1'b1, 4);
      drive(2'd3, 2'd0, 4'b1010, 8'b11_00_01_00, 1'b1, 2);

      // round-robin sweep, then lone ch2 moves the pointer to 3
      drive(2'd2, 2'd0, 4'b1111, 8'b11_10_01_00, 1'b1, 8);
      drive(2'd2, 2'd0, 4'b0100, 8'b11_10_01_00, 1'b1, 1);
      drive(2'd2, 2'd0, 4'b1111, 8'b11_10_01_00, 1'b1, 2);

      // key select: sel=2 idle drains, then ch2 granted
      drive(2'd0, 2'd2, 4'b0011, 8'b00_10_01_11, 1'b1, 2);
      drive(2'd0, 2'd2, 4'b0111, 8'b00_10_01_11, 1'b1, 2);

      // backpressure: hold 2'b11 for 5 cycles, then drain and refill together
      drive(2'd1, 2'd0, 4'b1000, 8'b11_00_00_00, 1'b1, 1);
      drive(2'd1, 2'd0, 4'b1111, 8'b11_00_00_01, 1'b0, 5);
      drive(2'd1, 2'd0, 4'b1111, 8'b11_00_00_01, 1'b1, 2);

      // random mix of modes, keys, requests and sink stalls
      for (int i = 0; i < 60; i++) begin
         drive(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 4'($urandom),
               8'($urandom), 1'($urandom_range(0, 3) != 0), 1);
      end

      // three-channel instance: out-of-range key
      drive(2'd1, 2'd0, 4'b0111, 8'h1B, 1'b1, 1);
      check("dut3_load_valid", 32'(out_valid3), 32'd1);
      mode = 2'd0;
      sel  = 2'd3;
      #1;
      check("dut3_in_ready_sel3", 32'(in_ready3), 32'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         check("dut3_sel_err_pulse", 32'(sel_err3), 32'd1);
         check("dut3_in_ready_sel3", 32'(in_ready3), 32'd0);
      end
      check("dut3_drained", 32'(out_valid3), 32'd0);

      // stalled register blocks the error pulse
      drive(2'd1, 2'd0, 4'b0111, 8'h1B, 1'b0, 1);
      check("dut3_reload_valid", 32'(out_valid3), 32'd1);
      check("dut3_reload_data", 32'(out_data3), 32'd3);
      drive(2'd0, 2'd3, 4'b0111, 8'h1B, 1'b0, 1);
      check("dut3_sel_err_stalled", 32'(sel_err3), 32'd0);
      drive(2'd0, 2'd3, 4'b0111, 8'h1B, 1'b0, 1);
      drive(2'd1, 2'd0, 4'b0111, 8'h1B, 1'b1, 1);
      check("dut3_refill_valid", 32'(out_valid3), 32'd1);
      drive(2'd0, 2'd3, 4'b0111, 8'h1B, 1'b0, 1);
      check("dut3_sel_err_stalled2", 32'(sel_err3), 32'd0);
      check("dut3_held_valid", 32'(out_valid3), 32'd1);
      drive(2'd0, 2'd3, 4'b0111, 8'h1B, 1'b1, 1);
      check("dut3_sel_err_drain", 32'(sel_err3), 32'd1);

      // reset mid-stream with a word in the register
      drive(2'd1, 2'd0, 4'b0110, 8'h2D, 1'b0, 1);
      check("dut3_pre_rst_valid", 32'(out_valid3), 32'd1);
      check("dut3_pre_rst_ch", 32'(out_ch3), 32'd1);
      mode = 2'd0;
      sel  = 2'd3;
      rst  = 1'b1;
      step();
      check("dut3_rst_valid", 32'(out_valid3), 32'd0);
      check("dut3_rst_data", 32'(out_data3), 32'd0);
      check("dut3_rst_ch", 32'(out_ch3), 32'd0);
      check("dut3_rst_sel_err", 32'(sel_err3), 32'd0);
      check("dut3_rst_in_ready", 32'(in_ready3), 32'd0);
      rst = 1'b0;
      drive(2'd1, 2'd0, 4'b0100, 8'h20, 1'b1, 1);
      check("dut3_post_rst_ch", 32'(out_ch3), 32'd2);
      check("dut3_post_rst_data", 32'(out_data3), 32'd2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
